// File: rtl/wb_arbiter.sv
// Writeback arbiter: two 2-entry request FIFOs (ALU, LSU) merged round-robin
// into a single registered register-file write port with a pending scoreboard.
module wb_arbiter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            rf_wen,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_wdata,
  output logic [31:0]     pending
);

  typedef enum logic {
    GRANT_ALU = 1'b0,
    GRANT_LSU = 1'b1
  } grant_t;

  // Index 0 is the ALU requester, index 1 the LSU requester.
  logic [1:0]      in_valid;
  logic [4:0]      in_rd   [2];
  logic [XLEN-1:0] in_data [2];

  logic [4:0]      q_rd    [2][2];
  logic [XLEN-1:0] q_data  [2][2];
  logic [1:0]      cnt     [2];
  logic [1:0]      rptr;
  logic [1:0]      wptr;

  logic [1:0]      rdy;
  logic [1:0]      nonempty;
  logic [1:0]      push;
  logic [1:0]      pop;

  grant_t          last_grant;
  grant_t          next_grant;
  logic            sel;
  logic [4:0]      head_rd;
  logic [XLEN-1:0] head_data;

  always_comb begin
    in_valid   = {lsu_valid, alu_valid};
    in_rd[0]   = alu_rd;
    in_rd[1]   = lsu_rd;
    in_data[0] = alu_data;
    in_data[1] = lsu_data;
  end

  // Ready is derived from occupancy only, so valid never reaches ready.
  always_comb begin
    rdy      = '0;
    nonempty = '0;
    push     = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      rdy[i]      = (cnt[i] != 2'd2);
      nonempty[i] = (cnt[i] != 2'd0);
      push[i]     = in_valid[i] && rdy[i];
    end
  end

  assign alu_ready = rdy[0];
  assign lsu_ready = rdy[1];

  always_comb begin
    pop        = '0;
    next_grant = last_grant;
    if (nonempty[0] && nonempty[1]) begin
      if (last_grant == GRANT_LSU) begin
        pop[0]     = 1'b1;
        next_grant = GRANT_ALU;
      end else begin
        pop[1]     = 1'b1;
        next_grant = GRANT_LSU;
      end
    end else if (nonempty[0]) begin
      pop[0]     = 1'b1;
      next_grant = GRANT_ALU;
    end else if (nonempty[1]) begin
      pop[1]     = 1'b1;
      next_grant = GRANT_LSU;
    end
  end

  always_comb begin
    sel       = pop[1];
    head_rd   = q_rd[sel][rptr[sel]];
    head_data = q_data[sel][rptr[sel]];
  end

  // Storage needs no reset: occupancy alone decides which slots are live.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 2; i++) begin
      if (push[i]) begin
        q_rd[i][wptr[i]]   <= in_rd[i];
        q_data[i][wptr[i]] <= in_data[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '{default: '0};
      rptr       <= '0;
      wptr       <= '0;
      last_grant <= GRANT_LSU;
      rf_wen     <= 1'b0;
      rf_rd      <= '0;
      rf_wdata   <= '0;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (push[i]) wptr[i] <= ~wptr[i];
        if (pop[i])  rptr[i] <= ~rptr[i];
        cnt[i] <= cnt[i] + 2'(push[i]) - 2'(pop[i]);
      end
      last_grant <= next_grant;
      rf_wen     <= (|pop) && (head_rd != 5'd0);
      if (|pop) begin
        rf_rd    <= head_rd;
        rf_wdata <= head_data;
      end
    end
  end

  always_comb begin
    pending = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      for (int unsigned e = 0; e < 2; e++) begin
        if ((cnt[i] == 2'd2) || ((cnt[i] == 2'd1) && (rptr[i] == 1'(e))))
          pending[q_rd[i][e]] = 1'b1;
      end
    end
    if (rf_wen) pending[rf_rd] = 1'b1;
    pending[0] = 1'b0;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the data width of every write-data port.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, with asynchronous active-high reset.
REQ-004 The block SHALL have ports alu_valid, input, 1, and alu_ready, output, 1, forming the ALU writeback request handshake.
REQ-005 The block SHALL have ports alu_rd, input, 5, and alu_data, input, XLEN, carrying the ALU destination register and value.
REQ-006 The block SHALL have ports lsu_valid, input, 1, and lsu_ready, output, 1, forming the load-unit writeback request handshake.
REQ-007 The block SHALL have ports lsu_rd, input, 5, and lsu_data, input, XLEN, carrying the load destination register and value.
REQ-008 The block SHALL have ports rf_wen, output, 1; rf_rd, output, 5; and rf_wdata, output, XLEN, which drive the register-file write port.
REQ-009 The block SHALL have port pending, output, 32, flagging registers with an accepted but not yet completed write.

Function
REQ-010 Each requester SHALL own a 2-entry FIFO holding {rd, data}.
REQ-011 A transfer SHALL occur on a rising edge when valid and ready are both 1; the entry is pushed at that edge.
REQ-012 alu_ready and lsu_ready SHALL each be 1 exactly when the corresponding FIFO holds fewer than 2 entries; ready SHALL NOT depend on valid.
REQ-013 Each cycle, at most one FIFO head SHALL be popped and transferred into the output register.
REQ-014 When exactly one FIFO is non-empty, that FIFO's head SHALL be popped.
REQ-015 When both FIFOs are non-empty, round-robin SHALL apply: pop the requester not granted at the last pop; last_grant updates only on a pop.
REQ-016 After reset, last_grant SHALL equal LSU, so the ALU wins the first contended pop.
REQ-017 The output register SHALL capture the popped entry; rf_rd and rf_wdata SHALL equal the popped rd and data on the cycle after the pop (latency 1 from pop, minimum 1 cycle from handshake).
REQ-018 rf_wen SHALL be 1 for exactly one cycle per popped entry with rd != 0.
REQ-019 A popped entry with rd == 0 SHALL be consumed with rf_wen held 0, so writes to x0 are dropped.
REQ-020 When nothing is popped, rf_wen SHALL be 0 on the next cycle and rf_rd/rf_wdata SHALL hold their values.
REQ-021 A push and a pop on the same FIFO in the same cycle SHALL both take effect, leaving the occupancy unchanged.
REQ-022 Order SHALL be preserved within each requester; no ordering is guaranteed between requesters.
REQ-023 pending[i] SHALL be 1 when any valid FIFO entry or the output register while rf_wen is 1 targets register i, for i != 0; pending[0] SHALL be 0 always; pending is combinational from state.
REQ-024 The block SHALL be free of combinational paths from valid inputs to ready outputs and free of combinational loops.

Reset
REQ-025 While rst is 1, both FIFOs SHALL be emptied, last_grant SHALL equal LSU, and the outputs SHALL be rf_wen=0, rf_rd=0, rf_wdata=0, pending=0, alu_ready=1 and lsu_ready=1, asynchronously.
REQ-026 Assertion of rst mid-operation SHALL discard all queued entries without producing any further rf_wen pulse.

Verification
REQ-027 ALU only: alu_rd=5, alu_data=0xDEADBEEF handshakes at edge N -> rf_wen=1, rf_rd=5, rf_wdata=0xDEADBEEF after edge N+1 for one cycle, and pending[5]=1 from edge N until the cycle after that pulse.
REQ-028 Contention: ALU (rd=1, data 0x11) and LSU (rd=2, data 0x22) both handshake at the same edge after reset -> rd=1 is written on the first write cycle and rd=2 on the next cycle.
REQ-029 Back-pressure: lsu_valid=1 with alu_valid=1 held continuously -> lsu_ready never drops below a 50% grant share, writes alternate ALU/LSU, and no entry is lost or reordered per requester.
REQ-030 x0 write: alu_rd=0, alu_data=0x1234 -> the entry is consumed, rf_wen stays 0, pending stays 0, and alu_ready returns to 1.
REQ-031 Full FIFO: two ALU entries queued while the LSU keeps winning is impossible by construction; instead, push 3 ALU entries in consecutive cycles with the output busy -> alu_ready=0 when the FIFO holds 2, and all 3 writes appear in order.
REQ-032 Reset mid-operation: assert rst with 2 entries queued per FIFO -> rf_wen=0 immediately, pending=0, and no write appears after rst is released.
